// File: rtl/pe_row_conv_acc.sv
// K-tap row convolver that accumulates several kernel rows into a psum row buffer
// and streams the finished output row through a first-word-fall-through FIFO.
module pe_row_conv_acc #(
  parameter int unsigned ACT_W      = 8,
  parameter int unsigned WGT_W      = 8,
  parameter int unsigned PSUM_W     = 24,
  parameter int unsigned K          = 3,
  parameter int unsigned ROW_LEN    = 16,
  parameter int unsigned MAX_ROWS   = 7,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start_i,
  input  logic [$clog2(MAX_ROWS+1)-1:0]    num_rows_i,
  input  logic                             signed_mode_i,
  input  logic                             wgt_valid_i,
  output logic                             wgt_ready_o,
  input  logic [K*WGT_W-1:0]               wgt_i,
  input  logic                             act_valid_i,
  output logic                             act_ready_o,
  input  logic [ACT_W-1:0]                 act_i,
  input  logic                             act_last_i,
  output logic                             psum_valid_o,
  input  logic                             psum_ready_i,
  output logic [PSUM_W-1:0]                psum_o,
  output logic                             psum_last_o,
  output logic                             busy_o,
  output logic                             done_o,
  output logic                             err_o
);

  localparam int NrW      = $clog2(MAX_ROWS + 1);
  localparam int OutN     = ROW_LEN - K + 1;
  localparam int OutCntW  = $clog2(OutN + 1);
  localparam int BufAw    = (OutN > 1) ? $clog2(OutN) : 1;
  localparam int ActCntW  = $clog2(ROW_LEN + 2);
  localparam int HistN    = (K > 1) ? K - 1 : 1;
  localparam int HistTop  = int'(K) - 2;
  localparam int LastTap  = int'(K) - 1;
  localparam int FifoAw   = $clog2(FIFO_DEPTH);
  localparam int FifoCntW = $clog2(FIFO_DEPTH + 1);

  localparam logic [ActCntW-1:0]  TapsM1   = ActCntW'(K - 1);
  localparam logic [ActCntW-1:0]  RowLenC  = ActCntW'(ROW_LEN);
  localparam logic [FifoCntW-1:0] FifoFull = FifoCntW'(FIFO_DEPTH);
  localparam logic [FifoAw-1:0]   FifoLast = FifoAw'(FIFO_DEPTH - 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StWload = 2'd1;
  localparam logic [1:0] StRun   = 2'd2;
  localparam logic [1:0] StDrain = 2'd3;

  logic [1:0]           state_q, state_d;
  logic [NrW-1:0]       last_row_q;
  logic [NrW-1:0]       row_q;
  logic                 signed_q;
  logic [K*WGT_W-1:0]   wgt_q;
  logic [ACT_W-1:0]     hist_q [HistN];
  logic [ActCntW-1:0]   act_cnt_q;
  logic [OutCntW-1:0]   out_idx_q;
  logic [OutCntW-1:0]   row0_len_q;
  logic                 err_q;
  logic                 done_q;
  logic [PSUM_W-1:0]    buf_q [OutN];

  logic [PSUM_W:0]      fifo_mem [FIFO_DEPTH];
  logic [FifoAw-1:0]    wr_ptr_q, rd_ptr_q;
  logic [FifoCntW-1:0]  fifo_cnt_q;

  logic                 final_row, first_row;
  logic                 wgt_fire, act_fire, in_len, produce, in_range;
  logic                 buf_we, push, pop, row_end, row_err, excess_err;
  logic [BufAw-1:0]     buf_idx;
  logic [OutCntW-1:0]   out_cnt_row;
  logic [PSUM_W-1:0]    conv_sum, acc_val;

  function automatic logic [PSUM_W-1:0] ext_act(input logic [ACT_W-1:0] v, input logic sgn);
    return sgn ? {{(PSUM_W-ACT_W){v[ACT_W-1]}}, v} : {{(PSUM_W-ACT_W){1'b0}}, v};
  endfunction

  function automatic logic [PSUM_W-1:0] ext_wgt(input logic [WGT_W-1:0] v, input logic sgn);
    return sgn ? {{(PSUM_W-WGT_W){v[WGT_W-1]}}, v} : {{(PSUM_W-WGT_W){1'b0}}, v};
  endfunction

  // Taps 0..K-2 come from the history of earlier acts; the newest tap is the act
  // being accepted, so the result is ready on the accepting edge.
  always_comb begin
    conv_sum = '0;
    for (int k = 0; k < int'(K); k++) begin
      conv_sum = conv_sum + ext_wgt(wgt_q[k*WGT_W +: WGT_W], signed_q) *
                 ext_act((k == LastTap) ? act_i : hist_q[k % HistN], signed_q);
    end
  end

  always_comb begin
    final_row   = (row_q == last_row_q);
    first_row   = (row_q == '0);
    wgt_ready_o = (state_q == StWload);
    act_ready_o = (state_q == StRun) && (!final_row || (fifo_cnt_q < FifoFull));
    wgt_fire    = wgt_valid_i && wgt_ready_o;
    act_fire    = act_valid_i && act_ready_o;
    in_len      = (act_cnt_q < RowLenC);
    produce     = act_fire && in_len && (act_cnt_q >= TapsM1);
    // Later rows may not extend past the output count established by row 0.
    in_range    = first_row || (out_idx_q < row0_len_q);
    buf_idx     = out_idx_q[BufAw-1:0];
    acc_val     = first_row ? conv_sum : buf_q[buf_idx] + conv_sum;
    buf_we      = produce && in_range && !final_row;
    push        = produce && in_range && final_row;
    pop         = psum_valid_o && psum_ready_i;
    row_end     = act_fire && act_last_i;
    out_cnt_row = out_idx_q + OutCntW'(produce);
    row_err     = row_end && ((act_cnt_q < TapsM1) ||
                              (!first_row && (out_cnt_row != row0_len_q)));
    excess_err  = act_fire && !in_len;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start_i) state_d = StWload;
      StWload: if (wgt_fire) state_d = StRun;
      StRun:   if (row_end) state_d = final_row ? StDrain : StWload;
      StDrain: if (fifo_cnt_q == '0) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      last_row_q <= '0;
      row_q      <= '0;
      signed_q   <= 1'b0;
      wgt_q      <= '0;
      act_cnt_q  <= '0;
      out_idx_q  <= '0;
      row0_len_q <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      for (int i = 0; i < HistN; i++) hist_q[i] <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      if ((state_q == StIdle) && start_i) begin
        last_row_q <= (num_rows_i == '0) ? '0 : num_rows_i - NrW'(1);
        signed_q   <= signed_mode_i;
        err_q      <= 1'b0;
        row_q      <= '0;
      end
      if (wgt_fire) begin
        wgt_q     <= wgt_i;
        act_cnt_q <= '0;
        out_idx_q <= '0;
      end
      if (act_fire) begin
        if (act_cnt_q <= RowLenC) act_cnt_q <= act_cnt_q + ActCntW'(1);
        for (int i = 0; i < HistN; i++) begin
          if (i == HistTop) hist_q[i] <= act_i;
          else              hist_q[i] <= hist_q[(i + 1) % HistN];
        end
      end
      if (produce) out_idx_q <= out_idx_q + OutCntW'(1);
      if (row_end) begin
        if (first_row)  row0_len_q <= out_cnt_row;
        if (!final_row) row_q      <= row_q + NrW'(1);
      end
      if (row_err || excess_err) err_q <= 1'b1;
      if ((state_q == StDrain) && (fifo_cnt_q == '0)) done_q <= 1'b1;
    end
  end

  // Row 0 overwrites every entry it uses, so the buffer needs no reset.
  always_ff @(posedge clk) begin
    if (buf_we) buf_q[buf_idx] <= acc_val;
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= {act_last_i, acc_val};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (push) wr_ptr_q <= (wr_ptr_q == FifoLast) ? '0 : wr_ptr_q + FifoAw'(1);
      if (pop)  rd_ptr_q <= (rd_ptr_q == FifoLast) ? '0 : rd_ptr_q + FifoAw'(1);
      if (push && !pop)      fifo_cnt_q <= fifo_cnt_q + FifoCntW'(1);
      else if (pop && !push) fifo_cnt_q <= fifo_cnt_q - FifoCntW'(1);
    end
  end

  always_comb begin
    psum_valid_o = (fifo_cnt_q != '0);
    psum_o       = psum_valid_o ? fifo_mem[rd_ptr_q][PSUM_W-1:0] : '0;
    psum_last_o  = psum_valid_o ? fifo_mem[rd_ptr_q][PSUM_W] : 1'b0;
    busy_o       = (state_q != StIdle);
    done_o       = done_q;
    err_o        = err_q;
  end

endmodule

// File: tb/tb_pe_row_conv_acc.sv
// Bench for pe_row_conv_acc: directed cases plus randomized jobs checked against
// a plain-arithmetic model of the 2-D row convolution.
module tb_pe_row_conv_acc;

  localparam int ACT_W      = 8;
  localparam int WGT_W      = 8;
  localparam int PSUM_W     = 24;
  localparam int K          = 3;
  localparam int ROW_LEN    = 16;
  localparam int MAX_ROWS   = 7;
  localparam int FIFO_DEPTH = 4;
  localparam int NrW        = $clog2(MAX_ROWS + 1);

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                start;
  logic [NrW-1:0]      num_rows;
  logic                signed_mode;
  logic                wgt_valid, wgt_ready;
  logic [K*WGT_W-1:0]  wgt;
  logic                act_valid, act_ready, act_last;
  logic [ACT_W-1:0]    act;
  logic                psum_valid, psum_ready, psum_last;
  logic [PSUM_W-1:0]   psum;
  logic                busy, done, err;

  int n_checks = 0;
  int n_pass   = 0;
  int wts   [MAX_ROWS][K];
  int act_a [MAX_ROWS][ROW_LEN+4];
  logic [PSUM_W:0] exp_q[$];
  logic [PSUM_W:0] got_q[$];
  bit   exp_err;
  int   rdy_mode = 1;
  bit   gaps = 0;
  int   stab_err = 0;
  bit   held_v = 0;
  logic [PSUM_W:0] held;

  always #5 clk = ~clk;

  pe_row_conv_acc #(
    .ACT_W(ACT_W), .WGT_W(WGT_W), .PSUM_W(PSUM_W), .K(K),
    .ROW_LEN(ROW_LEN), .MAX_ROWS(MAX_ROWS), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .num_rows_i(num_rows),
    .signed_mode_i(signed_mode), .wgt_valid_i(wgt_valid), .wgt_ready_o(wgt_ready),
    .wgt_i(wgt), .act_valid_i(act_valid), .act_ready_o(act_ready), .act_i(act),
    .act_last_i(act_last), .psum_valid_o(psum_valid), .psum_ready_i(psum_ready),
    .psum_o(psum), .psum_last_o(psum_last), .busy_o(busy), .done_o(done), .err_o(err)
  );

  // psum_ready: 0 = held low, 1 = held high, 2 = random per cycle
  initial begin
    psum_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0:       psum_ready = 1'b0;
        1:       psum_ready = 1'b1;
        default: psum_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Records each output handshake and checks that a stalled head stays put.
  always @(negedge clk) begin
    if (psum_valid) begin
      if (held_v && ({psum_last, psum} !== held)) stab_err++;
      if (psum_ready) begin
        got_q.push_back({psum_last, psum});
        held_v = 0;
      end else begin
        held_v = 1;
        held   = {psum_last, psum};
      end
    end else begin
      held_v = 0;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_wgt(input int r);
    int n = 0;
    bit ok = 0;
    for (int k = 0; k < K; k++) wgt[k*WGT_W +: WGT_W] = wts[r][k][WGT_W-1:0];
    wgt_valid = 1'b1;
    while (!ok && n < 4000) begin
      @(negedge clk);
      ok = wgt_ready;
      step();
      n++;
    end
    wgt_valid = 1'b0;
    if (!ok) check("wgt_handshake_timeout", 64'(ok), 64'd1);
  endtask

  task automatic send_act(input int a, input bit last);
    int n = 0;
    bit ok = 0;
    act       = a[ACT_W-1:0];
    act_last  = last;
    act_valid = 1'b1;
    while (!ok && n < 4000) begin
      @(negedge clk);
      ok = act_ready;
      step();
      n++;
    end
    act_valid = 1'b0;
    act_last  = 1'b0;
    if (!ok) check("act_handshake_timeout", 64'(ok), 64'd1);
  endtask

  function automatic longint opnd(input int v, input bit sgn);
    return (sgn && v >= 128) ? longint'(v - 256) : longint'(v);
  endfunction

  // out[j] = sum over rows r and taps k of w[r][k] * a[r][j+k], modulo 2^PSUM_W
  task automatic model(input int nr, input bit sgn, input int len);
    int nre = (nr == 0) ? 1 : nr;
    int nout;
    longint s;
    logic [63:0] sv;
    exp_q.delete();
    nout = (len < K) ? 0 : (((len > ROW_LEN) ? ROW_LEN : len) - K + 1);
    for (int j = 0; j < nout; j++) begin
      s = 0;
      for (int r = 0; r < nre; r++)
        for (int k = 0; k < K; k++)
          s += opnd(wts[r][k], sgn) * opnd(act_a[r][j+k], sgn);
      sv = 64'(s);
      exp_q.push_back({(j == nout - 1), sv[PSUM_W-1:0]});
    end
    exp_err = (len < K) || (len > ROW_LEN);
  endtask

  task automatic wait_done();
    int n = 0;
    bit seen = 0;
    int m;
    while (!seen && n < 4000) begin
      @(negedge clk);
      seen = done;
      n++;
    end
    check("done_seen", 64'(seen), 64'd1);
    if (seen) begin
      check("idle_at_done", 64'(busy), 64'd0);
      check("err_at_done", 64'(err), 64'(exp_err));
      @(negedge clk);
      check("done_one_cycle", 64'(done), 64'd0);
    end
    step();
    check("out_count", 64'(got_q.size()), 64'(exp_q.size()));
    m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < m; i++)
      check($sformatf("psum[%0d]", i), 64'(got_q[i]), 64'(exp_q[i]));
    check("fwft_stable", 64'(stab_err), 64'd0);
  endtask

  task automatic run_job(input int nr, input bit sgn, input int len, input bit use_model,
                         input bit exp_e);
    int nre = (nr == 0) ? 1 : nr;
    if (use_model) model(nr, sgn, len);
    else exp_err = exp_e;
    got_q.delete();
    stab_err    = 0;
    num_rows    = nr[NrW-1:0];
    signed_mode = sgn;
    start       = 1'b1;
    step();
    start       = 1'b0;
    @(negedge clk);
    check("busy_after_start", 64'(busy), 64'd1);
    check("err_clear_on_start", 64'(err), 64'd0);
    step();
    for (int r = 0; r < nre; r++) begin
      send_wgt(r);
      for (int i = 0; i < len; i++) begin
        if (gaps) repeat ($urandom_range(0, 2)) step();
        send_act(act_a[r][i], i == len - 1);
      end
      if (r < nre - 1) begin
        @(negedge clk);
        check("wgt_ready_between_rows", 64'(wgt_ready), 64'd1);
        check("no_push_before_final", 64'(psum_valid), 64'd0);
        step();
      end
    end
    wait_done();
  endtask

  task automatic set_row(input int r, input int w0, input int w1, input int w2);
    wts[r][0] = w0;
    wts[r][1] = w1;
    wts[r][2] = w2;
    for (int i = 0; i < ROW_LEN + 4; i++) act_a[r][i] = i + 1;
  endtask

  initial begin
    start = 0; num_rows = '0; signed_mode = 0; wgt_valid = 0; wgt = '0;
    act_valid = 0; act = '0; act_last = 0;
    rdy_mode = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_psum_valid", 64'(psum_valid), 64'd0);
    check("rst_psum", 64'(psum), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_wgt_ready", 64'(wgt_ready), 64'd0);
    check("rst_act_ready", 64'(act_ready), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    rst_n = 1'b1;
    step();

    // Basic row
    set_row(0, 1, 2, 3);
    exp_q = '{{1'b0, 24'd14}, {1'b0, 24'd20}, {1'b1, 24'd26}};
    run_job(1, 0, 5, 0, 0);

    // Two-row accumulate
    set_row(0, 1, 1, 1);
    set_row(1, 1, 2, 3);
    exp_q = '{{1'b0, 24'd20}, {1'b0, 24'd29}, {1'b1, 24'd38}};
    run_job(2, 0, 5, 0, 0);

    // Sign mode
    wts[0][0] = 2; wts[0][1] = 2; wts[0][2] = 2;
    for (int i = 0; i < 3; i++) act_a[0][i] = 255;
    exp_q = '{{1'b1, 24'hFFFFFA}};
    run_job(1, 1, 3, 0, 0);
    exp_q = '{{1'b1, 24'd1530}};
    run_job(1, 0, 3, 0, 0);

    // Backpressure on the final row
    rdy_mode = 0;
    step();
    step();
    set_row(0, 1, 2, 3);
    exp_q = '{{1'b0, 24'd14}, {1'b0, 24'd20}, {1'b0, 24'd26},
              {1'b0, 24'd32}, {1'b0, 24'd38}, {1'b1, 24'd44}};
    exp_err = 0;
    got_q.delete();
    stab_err = 0;
    num_rows = NrW'(1);
    signed_mode = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    send_wgt(0);
    for (int i = 0; i < 6; i++) send_act(i + 1, 0);
    act = 8'd7;
    act_valid = 1'b1;
    @(negedge clk);
    check("bp_act_ready_low", 64'(act_ready), 64'd0);
    check("bp_fifo_valid", 64'(psum_valid), 64'd1);
    check("bp_fwft_head", 64'({psum_last, psum}), 64'({1'b0, 24'd14}));
    repeat (3) step();
    @(negedge clk);
    check("bp_still_stalled", 64'(act_ready), 64'd0);
    step();
    rdy_mode = 1;
    send_act(7, 0);
    send_act(8, 1);
    wait_done();

    // Short row
    set_row(0, 1, 2, 3);
    exp_q.delete();
    run_job(1, 0, 2, 0, 1);

    // Randomized jobs with random gaps and random output backpressure
    rdy_mode = 2;
    gaps = 1;
    for (int t = 0; t < 8; t++) begin
      int nr  = $urandom_range(0, MAX_ROWS);
      int len = $urandom_range(K, ROW_LEN);
      bit sgn = 1'($urandom_range(0, 1));
      for (int r = 0; r < MAX_ROWS; r++) begin
        for (int k = 0; k < K; k++) wts[r][k] = $urandom_range(0, 255);
        for (int i = 0; i < ROW_LEN + 4; i++) act_a[r][i] = $urandom_range(0, 255);
      end
      run_job(nr, sgn, len, 1, 0);
    end
    gaps = 0;

    // Reset in the middle of the final row with two outputs pending
    rdy_mode = 0;
    step();
    step();
    set_row(0, 1, 2, 3);
    num_rows = NrW'(1);
    start = 1'b1;
    step();
    start = 1'b0;
    send_wgt(0);
    for (int i = 0; i < 4; i++) send_act(i + 1, 0);
    @(negedge clk);
    check("pre_reset_pending", 64'(psum_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_psum_valid", 64'(psum_valid), 64'd0);
    check("mid_rst_psum", 64'(psum), 64'd0);
    check("mid_rst_psum_last", 64'(psum_last), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_act_ready", 64'(act_ready), 64'd0);
    check("mid_rst_wgt_ready", 64'(wgt_ready), 64'd0);
    check("mid_rst_done", 64'(done), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    rdy_mode = 1;
    step();
    exp_q = '{{1'b0, 24'd14}, {1'b0, 24'd20}, {1'b1, 24'd26}};
    run_job(1, 0, 5, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
